// File: rtl/sop_thr_pkg.sv
// rtl/sop_thr_pkg.sv - shared types and step classification for the SOP threshold controller
// Contents:
//   adj_e     : threshold adjustment decision, ordered coarse-up .. hold .. coarse-down
//   lock_st_e : per-channel lock state
//   classify  : maps a window SOP count onto an adjustment decision
package sop_thr_pkg;

  // Ordering matters: every value below ADJ_HOLD is an increase.
  typedef enum logic [2:0] {
    ADJ_UP1,
    ADJ_UP2,
    ADJ_UP3,
    ADJ_HOLD,
    ADJ_DN3,
    ADJ_DN2,
    ADJ_DN1
  } adj_e;

  typedef enum logic {
    ST_UNLOCK,
    ST_LOCK
  } lock_st_e;

  function automatic adj_e classify(input int count, input int target,
                                    input int bord1, input int bord2, input int bord3);
    adj_e r;
    if      (count > target + bord1) r = ADJ_UP1;
    else if (count > target + bord2) r = ADJ_UP2;
    else if (count > target + bord3) r = ADJ_UP3;
    else if (count < target - bord1) r = ADJ_DN1;
    else if (count < target - bord2) r = ADJ_DN2;
    else if (count < target - bord3) r = ADJ_DN3;
    else                             r = ADJ_HOLD;
    return r;
  endfunction

endpackage

// File: rtl/sop_thr_ch.sv
// rtl/sop_thr_ch.sv - one channel: SOP accumulator, window count, auto threshold, lock FSM
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sop          : SOP pulse for this channel
//   i_auto_en      : adaptation enable
//   i_wend         : last cycle of the shared window
//   i_thr_load     : load i_thr_init (clamped) into the threshold
//   i_thr_init     : initial/manual threshold
//   o_thr          : current threshold
//   o_n_sps        : SOP count of the last completed window
//   o_locked       : channel has been in band for LOCK_WIN windows
module sop_thr_ch
  import sop_thr_pkg::*;
#(
  parameter int THR_W    = 24,
  parameter int CNT_W    = 15,
  parameter int TARGET   = 20,
  parameter int STEP1    = 15,
  parameter int STEP2    = 5,
  parameter int STEP3    = 2,
  parameter int BORD1    = 10,
  parameter int BORD2    = 5,
  parameter int BORD3    = 2,
  parameter int THR_MIN  = 30,
  parameter int THR_MAX  = (2**THR_W) - 1,
  parameter int LOCK_WIN = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sop,
  input  logic             i_auto_en,
  input  logic             i_wend,
  input  logic             i_thr_load,
  input  logic [THR_W-1:0] i_thr_init,
  output logic [THR_W-1:0] o_thr,
  output logic [CNT_W-1:0] o_n_sps,
  output logic             o_locked
);

  localparam int LCW = $clog2(LOCK_WIN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // One extra bit so increments and clamp comparisons never wrap.
  localparam logic [THR_W:0] MIN_X = (THR_W+1)'(THR_MIN);
  localparam logic [THR_W:0] MAX_X = (THR_W+1)'(THR_MAX);

  logic [CNT_W-1:0] r_acc;
  logic [CNT_W-1:0] r_n_sps;
  logic [CNT_W-1:0] w_cnt;
  logic [THR_W-1:0] r_thr;
  logic [THR_W-1:0] w_thr_nxt;
  logic [THR_W:0]   w_thr_x;
  logic [THR_W:0]   w_init_x;
  logic [THR_W:0]   w_step;
  logic [THR_W:0]   w_sum;
  logic [THR_W:0]   w_diff;
  adj_e             w_adj;
  int               w_err;
  logic             w_in_band;
  logic             w_out_wide;
  lock_st_e         r_state;
  lock_st_e         w_state_nxt;
  logic [LCW-1:0]   r_lock_cnt;
  logic [LCW-1:0]   w_lock_cnt_nxt;

  // Count including a SOP on this very cycle, saturating; on wend this is the window total.
  assign w_cnt = (i_sop && (r_acc != CNT_MAX)) ? r_acc + 1'b1 : r_acc;

  always_comb begin
    w_err      = int'(w_cnt) - TARGET;
    w_in_band  = (w_err <= BORD3) && (w_err >= -BORD3);
    w_out_wide = (w_err > BORD2) || (w_err < -BORD2);
    w_adj      = classify(int'(w_cnt), TARGET, BORD1, BORD2, BORD3);
  end

  always_comb begin
    w_thr_x  = {1'b0, r_thr};
    w_init_x = {1'b0, i_thr_init};
    case (w_adj)
      ADJ_UP1, ADJ_DN1: w_step = (THR_W+1)'(STEP1);
      ADJ_UP2, ADJ_DN2: w_step = (THR_W+1)'(STEP2);
      ADJ_UP3, ADJ_DN3: w_step = (THR_W+1)'(STEP3);
      default:          w_step = '0;
    endcase
    w_sum     = w_thr_x + w_step;
    w_diff    = w_thr_x - w_step;
    w_thr_nxt = r_thr;
    // Load wins over a coincident window adjustment.
    if (i_thr_load) begin
      if (w_init_x < MIN_X)      w_thr_nxt = MIN_X[THR_W-1:0];
      else if (w_init_x > MAX_X) w_thr_nxt = MAX_X[THR_W-1:0];
      else                       w_thr_nxt = i_thr_init;
    end else if (i_wend && i_auto_en) begin
      if (w_adj < ADJ_HOLD) begin
        w_thr_nxt = (w_sum > MAX_X) ? MAX_X[THR_W-1:0] : w_sum[THR_W-1:0];
      end else if (w_adj != ADJ_HOLD) begin
        w_thr_nxt = (w_thr_x < MIN_X + w_step) ? MIN_X[THR_W-1:0] : w_diff[THR_W-1:0];
      end
    end
  end

  // Lock entry needs the tight band, exit needs the wider one (hysteresis).
  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    if (i_thr_load || !i_auto_en) begin
      w_state_nxt    = ST_UNLOCK;
      w_lock_cnt_nxt = '0;
    end else if (i_wend) begin
      case (r_state)
        ST_UNLOCK: begin
          if (w_in_band) begin
            w_lock_cnt_nxt = r_lock_cnt + 1'b1;
            if (w_lock_cnt_nxt == LCW'(LOCK_WIN)) w_state_nxt = ST_LOCK;
          end else begin
            w_lock_cnt_nxt = '0;
          end
        end
        ST_LOCK: begin
          if (w_out_wide) begin
            w_state_nxt    = ST_UNLOCK;
            w_lock_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt    = ST_UNLOCK;
          w_lock_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_UNLOCK;
      r_lock_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc   <= '0;
      r_n_sps <= '0;
      r_thr   <= MIN_X[THR_W-1:0];
    end else begin
      r_acc <= i_wend ? '0 : w_cnt;
      if (i_wend) r_n_sps <= w_cnt;
      r_thr <= w_thr_nxt;
    end
  end

  assign o_thr    = r_thr;
  assign o_n_sps  = r_n_sps;
  assign o_locked = (r_state == ST_LOCK);

endmodule

// File: rtl/sop_thr_ctrl_mc.sv
// rtl/sop_thr_ctrl_mc.sv - multi-channel SOP-rate driven correlator threshold controller
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sop          : per-channel SOP pulses
//   i_auto_en      : per-channel adaptation enable
//   i_thr_load     : load i_thr_init into all channels
//   i_thr_init     : packed initial thresholds, channel 0 in the LSBs
//   o_thr_auto     : packed current thresholds
//   o_n_sps        : packed SOP counts of the last completed window
//   o_win_done     : one-cycle strobe after each window end
//   o_locked       : per-channel lock indication
module sop_thr_ctrl_mc
  import sop_thr_pkg::*;
#(
  parameter int N_CH     = 4,
  parameter int THR_W    = 24,
  parameter int CNT_W    = 15,
  parameter int WIN_LEN  = 1056000,
  parameter int TARGET   = 20,
  parameter int STEP1    = 15,
  parameter int STEP2    = 5,
  parameter int STEP3    = 2,
  parameter int BORD1    = 10,
  parameter int BORD2    = 5,
  parameter int BORD3    = 2,
  parameter int THR_MIN  = 30,
  parameter int THR_MAX  = (2**THR_W) - 1,
  parameter int LOCK_WIN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_sop,
  input  logic [N_CH-1:0]       i_auto_en,
  input  logic                  i_thr_load,
  input  logic [N_CH*THR_W-1:0] i_thr_init,
  output logic [N_CH*THR_W-1:0] o_thr_auto,
  output logic [N_CH*CNT_W-1:0] o_n_sps,
  output logic                  o_win_done,
  output logic [N_CH-1:0]       o_locked
);

  localparam int WCW = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [WCW-1:0] WIN_LAST = WCW'(WIN_LEN - 1);

  logic [WCW-1:0] r_win_cnt;
  logic           r_win_done;
  logic           w_wend;

  assign w_wend = (r_win_cnt == WIN_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win_cnt  <= '0;
      r_win_done <= 1'b0;
    end else begin
      r_win_cnt  <= w_wend ? '0 : r_win_cnt + 1'b1;
      r_win_done <= w_wend;
    end
  end

  assign o_win_done = r_win_done;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    sop_thr_ch #(
      .THR_W(THR_W), .CNT_W(CNT_W), .TARGET(TARGET),
      .STEP1(STEP1), .STEP2(STEP2), .STEP3(STEP3),
      .BORD1(BORD1), .BORD2(BORD2), .BORD3(BORD3),
      .THR_MIN(THR_MIN), .THR_MAX(THR_MAX), .LOCK_WIN(LOCK_WIN)
    ) u_ch (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_sop      (i_sop[g]),
      .i_auto_en  (i_auto_en[g]),
      .i_wend     (w_wend),
      .i_thr_load (i_thr_load),
      .i_thr_init (i_thr_init[g*THR_W +: THR_W]),
      .o_thr      (o_thr_auto[g*THR_W +: THR_W]),
      .o_n_sps    (o_n_sps[g*CNT_W +: CNT_W]),
      .o_locked   (o_locked[g])
    );
  end

endmodule

// File: tb/tb_sop_thr_ctrl_mc.sv
// tb/tb_sop_thr_ctrl_mc.sv - self-checking bench for sop_thr_ctrl_mc
module tb_sop_thr_ctrl_mc;

  localparam int N_CH    = 4;
  localparam int THR_W   = 24;
  localparam int CNT_W   = 15;
  localparam int WIN_LEN = 100;
  localparam int TMAX    = (2**THR_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [N_CH-1:0]       sop = '0;
  logic [N_CH-1:0]       auto_en = '0;
  logic                  thr_load = 1'b0;
  logic [N_CH*THR_W-1:0] thr_init = '0;
  logic [N_CH*THR_W-1:0] thr_auto;
  logic [N_CH*CNT_W-1:0] n_sps;
  logic                  win_done;
  logic [N_CH-1:0]       locked;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sop_thr_ctrl_mc #(.N_CH(N_CH), .THR_W(THR_W), .CNT_W(CNT_W), .WIN_LEN(WIN_LEN)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sop      (sop),
    .i_auto_en  (auto_en),
    .i_thr_load (thr_load),
    .i_thr_init (thr_init),
    .o_thr_auto (thr_auto),
    .o_n_sps    (n_sps),
    .o_win_done (win_done),
    .o_locked   (locked)
  );

  // One record per window: per-channel SOP counts, whether the last SOP lands on
  // the wend cycle, enables, load timing (0 none, 1 first cycle, 2 wend cycle),
  // load values and expected thresholds / lock flags after the window.
  typedef struct {
    logic [3:0][31:0] n;
    logic [3:0]       wsop;
    logic [3:0]       en;
    int               ld;
    logic [3:0][31:0] init;
    logic [3:0][31:0] thr;
    logic [3:0]       lk;
  } row_t;

  typedef struct {
    int   ch;
    int   thr;
    int   nsps;
    logic lk;
  } exp_t;

  row_t rows[$];
  exp_t sb[$];

  task automatic chk(input string name, input int ch, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s ch%0d actual=%0d expected=%0d", name, ch, act, exp);
    end
  endtask

  function automatic row_t mk(input int n0, input int n1, input int n2, input int n3,
                              input logic [3:0] wsop, input logic [3:0] en, input int ld,
                              input int i0, input int i1, input int i2, input int i3,
                              input int t0, input int t1, input int t2, input int t3,
                              input logic [3:0] lk);
    row_t r;
    r.n[0] = n0;    r.n[1] = n1;    r.n[2] = n2;    r.n[3] = n3;
    r.init[0] = i0; r.init[1] = i1; r.init[2] = i2; r.init[3] = i3;
    r.thr[0] = t0;  r.thr[1] = t1;  r.thr[2] = t2;  r.thr[3] = t3;
    r.wsop = wsop;  r.en = en;      r.ld = ld;      r.lk = lk;
    return r;
  endfunction

  // Called with the current cycle being window cycle 0.
  task automatic apply_row(input row_t r);
    exp_t e;
    int   nc;
    for (int c = 0; c < N_CH; c++) begin
      thr_init[c*THR_W +: THR_W] = r.init[c][THR_W-1:0];
      e.ch = c; e.thr = int'(r.thr[c]); e.nsps = int'(r.n[c]); e.lk = r.lk[c];
      sb.push_back(e);
    end
    auto_en = r.en;
    for (int k = 0; k < WIN_LEN; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        nc = int'(r.n[c]);
        if (r.wsop[c] && nc != 0) sop[c] = (k < nc - 1) || (k == WIN_LEN - 1);
        else                      sop[c] = (k < nc);
      end
      thr_load = (r.ld == 1 && k == 0) || (r.ld == 2 && k == WIN_LEN - 1);
      @(posedge clk); #1;
      if (k == 0) chk("win_done_low", -1, win_done, 0);
    end
    sop = '0;
    thr_load = 1'b0;
    chk("win_done_high", -1, win_done, 1);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk("thr_auto", e.ch, thr_auto[e.ch*THR_W +: THR_W], e.thr);
      chk("n_sps", e.ch, n_sps[e.ch*CNT_W +: CNT_W], e.nsps);
      chk("locked", e.ch, locked[e.ch], e.lk);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    for (int c = 0; c < N_CH; c++) begin
      chk({tag, "_thr"}, c, thr_auto[c*THR_W +: THR_W], 30);
      chk({tag, "_nsps"}, c, n_sps[c*CNT_W +: CNT_W], 0);
      chk({tag, "_locked"}, c, locked[c], 0);
    end
    chk({tag, "_win_done"}, -1, win_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    //          n0  n1  n2  n3  wsop     en       ld  init0 init1 init2 init3      thr0  thr1 thr2 thr3       lk
    rows.push_back(mk(35, 24,  9, 40, 4'b0000, 4'b1111, 1, 1000, 500, 40, TMAX-3,    1015, 502, 30, TMAX,      4'b0000));
    rows.push_back(mk(20, 26, 20, 21, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               1015, 507, 30, TMAX,      4'b0000));
    rows.push_back(mk(20, 21, 20, 21, 4'b0001, 4'b1111, 0, 0, 0, 0, 0,               1015, 507, 30, TMAX,      4'b0000));
    rows.push_back(mk(20, 21, 20, 21, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               1015, 507, 30, TMAX,      4'b0000));
    rows.push_back(mk(19, 21, 20, 21, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               1015, 507, 30, TMAX,      4'b1101));
    rows.push_back(mk(24, 21, 26, 18, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               1017, 507, 35, TMAX,      4'b1011));
    rows.push_back(mk(40, 20, 40, 20, 4'b0000, 4'b1011, 0, 0, 0, 0, 0,               1032, 507, 35, TMAX,      4'b1010));
    rows.push_back(mk(40, 40, 40, 20, 4'b0000, 4'b1111, 2, 2000, 5, 100, TMAX,       2000, 30, 100, TMAX,      4'b0000));
    rows.push_back(mk( 5,  5,  5,  5, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               1985, 30, 85, TMAX-15,    4'b0000));
    rows.push_back(mk(21,  9, 35, 20, 4'b0000, 4'b1111, 0, 0, 0, 0, 0,               30, 30, 45, 30,           4'b0000));

    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_row(rows[i]);

    // Mid-window asynchronous reset: partial window is discarded.
    for (int k = 0; k < 50; k++) begin
      sop = (k % 2 == 0) ? 4'hF : 4'h0;
      @(posedge clk); #1;
    end
    sop = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    apply_row(rows[9]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
